palette_mapper: RTL
===================

// Module: palette_mapper
// PURPOSE
//  Pipelined colour-code to RGB mapper for the VGA path; sits between the sprite/tile compositor and the VGA DAC outputs.
//  Palette is a run-time-writable register file, loaded with the game's default colour table on reset.
//  Adds a frame-synchronised fade-to-black/fade-in engine (level transitions, game over) and forced blanking.
// PARAMETERS
//  CODE_W      6   colour-code width; palette depth = 2**CODE_W entries
//  COLOR_W     8   bits per colour channel
//  FADE_SHIFT  4   fade resolution; level range 0..2**FADE_SHIFT (0 = black, max = full colour)
//  FADE_PERIOD 2   frame_ticks per fade step (>=1)
// PORTS
//  Clk          in   1             system clock
//  Reset        in   1             asynchronous, active-high reset
//  pix_valid    in   1             colorcode/blank valid this cycle
//  colorcode    in   CODE_W        palette index
//  blank        in   1             force black for this pixel
//  pal_we       in   1             palette write strobe
//  pal_waddr    in   CODE_W        palette write index
//  pal_wdata    in   3*COLOR_W     {R,G,B} write data
//  frame_tick   in   1             one-cycle pulse per frame (vsync start)
//  fade_out_req in   1             pulse: start fading toward black
//  fade_in_req  in   1             pulse: start fading toward full colour
//  VGA_R/G/B    out  COLOR_W each  registered colour outputs
//  pix_valid_o  out  1             pix_valid delayed to align with VGA_R/G/B
//  fade_level   out  FADE_SHIFT+1  current fade level
//  fade_busy    out  1             high in FADE_OUT or FADE_IN
// BEHAVIOUR
//  Reset (async, active-high): VGA_R/G/B = 0, pix_valid_o = 0, fade state = IDLE, fade_level = 2**FADE_SHIFT, step counter = 0,
//   palette = DEFAULT_PALETTE. Reset asserted mid-fade or mid-write aborts the operation; no partial state survives.
//  Default table (RGB hex): 0 000000, 1 000000, 2 27b212, 3 d80222, 4 5db1f0, 5 f1ff0a, 6 b2b2b0, 7 f27a00,
//   8 663300, 9 8600b3, 10 000066, 11 ffffff, 12 70f248, 13 404040, 14 ffa64d, 15..max 404040.
//  Pipeline, latency 2, one pixel per cycle, no stalls:
//   S1: rgb1 <= palette[colorcode]; blank1 <= blank; v1 <= pix_valid.
//   S2: VGA_x <= blank1 ? 0 : (rgb1.x * fade_level) >> FADE_SHIFT; pix_valid_o <= v1.
//   Product width COLOR_W+FADE_SHIFT+1; result truncated to COLOR_W (never overflows since level <= 2**FADE_SHIFT).
//   Outputs update every cycle regardless of pix_valid; pix_valid=0 does not gate data.
//  Palette write: pal_we writes pal_wdata to pal_waddr at the clock edge. A read of the same index in the same cycle
//   returns the OLD value; the following cycle sees the new value.
//  Fade FSM (fade_level changes only on frame_tick, so a frame never mixes levels):
//   IDLE (level=max)   : fade_out_req -> FADE_OUT; fade_in_req ignored.
//   FADE_OUT           : every FADE_PERIOD frame_ticks level -= 1; on reaching 0 -> DARK.
//   DARK (level=0)     : fade_in_req -> FADE_IN; fade_out_req ignored.
//   FADE_IN            : every FADE_PERIOD frame_ticks level += 1; on reaching max -> IDLE.
//   fade_out_req in FADE_IN / fade_in_req in FADE_OUT: reverse direction from current level, step counter cleared.
//   Both requests in the same cycle: fade_out_req wins. Request coincident with frame_tick: state changes this cycle,
//   first level step occurs on a later tick (counter starts at 0 on entry).
//  fade_busy = (state==FADE_OUT || state==FADE_IN). fade_level is a registered output.
// STRUCTURE
//  palette_pkg: rgb_t struct {r,g,b}, fade_state_t enum {IDLE,FADE_OUT,DARK,FADE_IN}, DEFAULT_PALETTE constant,
//   colour-index localparams (C_BLACK, C_GREEN, ... C_LIGHT_BROWN).
//  Sub-module fade_ctrl: FSM + FADE_PERIOD tick counter + level register; palette_mapper holds palette regs and pipeline.
// TESTING
//  Reset, pix_valid=1, colorcode=2 -> 2 cycles later VGA={27,b2,12}, pix_valid_o=1; code 40 -> {40,40,40}.
//  pal_we addr=5 data=123456 with colorcode=5 same cycle -> out f1ff0a, next pixel 123456.
//  blank=1 with colorcode=11 -> VGA=0 at latency 2; blank=0 next -> ffffff.
//  FADE_SHIFT=4, FADE_PERIOD=2, fade_out_req, code 11 -> level 16->15 after 2 ticks, VGA=ef each; DARK after 32 ticks.
//  In FADE_OUT at level 8 pulse fade_in_req -> FADE_IN, level 9 after 2 ticks, IDLE at 16; fade_out+fade_in same cycle -> FADE_OUT.
//  Reset asserted mid-fade at level 5 after palette write -> level 16, IDLE, palette entry restored to default.

Source files
------------

// File: rtl/palette_pkg.sv
// Shared types and constants for the VGA palette mapper: colour record,
// fade engine states and the game's default colour table.
package palette_pkg;

  // Default geometry of the mapper.
  localparam int CODE_W_DEF      = 6;
  localparam int COLOR_W_DEF     = 8;
  localparam int FADE_SHIFT_DEF  = 4;
  localparam int FADE_PERIOD_DEF = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    DARK     = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_t;

  // Named colour indices of the default table.
  localparam int C_BLACK       = 0;
  localparam int C_BLACK_ALT   = 1;
  localparam int C_GREEN       = 2;
  localparam int C_RED         = 3;
  localparam int C_SKY_BLUE    = 4;
  localparam int C_YELLOW      = 5;
  localparam int C_GREY        = 6;
  localparam int C_ORANGE      = 7;
  localparam int C_BROWN       = 8;
  localparam int C_PURPLE      = 9;
  localparam int C_NAVY        = 10;
  localparam int C_WHITE       = 11;
  localparam int C_LIME        = 12;
  localparam int C_DARK_GREY   = 13;
  localparam int C_LIGHT_BROWN = 14;

  // Entry 15 doubles as the fill colour for every index above the named ones.
  localparam rgb_t DEFAULT_FILL = 24'h404040;
  localparam rgb_t DEFAULT_PALETTE [16] = '{
    24'h000000, 24'h000000, 24'h27b212, 24'hd80222,
    24'h5db1f0, 24'hf1ff0a, 24'hb2b2b0, 24'hf27a00,
    24'h663300, 24'h8600b3, 24'h000066, 24'hffffff,
    24'h70f248, 24'h404040, 24'hffa64d, 24'h404040
  };

  // Reset colour of any palette index.
  function automatic rgb_t default_rgb(input int idx);
    if (idx < 16) return DEFAULT_PALETTE[idx[3:0]];
    return DEFAULT_FILL;
  endfunction

endpackage

// File: rtl/palette_mapper_fade_ctrl.sv
// Frame-synchronised fade engine: state, frame-tick divider and level.
// The level only moves on frame_tick so a frame never mixes two levels.
module palette_mapper_fade_ctrl
  import palette_pkg::*;
#(
  parameter int FADE_SHIFT  = FADE_SHIFT_DEF,
  parameter int FADE_PERIOD = FADE_PERIOD_DEF
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_tick,
  input  logic                fade_out_req,
  input  logic                fade_in_req,
  output logic [FADE_SHIFT:0] level,
  output logic                busy
);

  localparam int LW = FADE_SHIFT + 1;
  localparam int CW = (FADE_PERIOD > 1) ? $clog2(FADE_PERIOD) : 1;
  localparam logic [LW-1:0] LVL_MAX  = LW'(2 ** FADE_SHIFT);
  localparam logic [CW-1:0] CNT_LAST = CW'(FADE_PERIOD - 1);

  fade_state_t   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [LW-1:0] level_reg, level_next;

  // State, tick divider and level registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      level_reg <= LVL_MAX;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
    end
  end

  // Next state: requests take precedence over a coincident tick, and a
  // reversal that finds the level already at its target ends immediately.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    level_next = level_reg;
    case (state_reg)
      IDLE: begin
        if (fade_out_req) begin
          state_next = FADE_OUT;
          cnt_next   = '0;
        end
      end
      FADE_OUT: begin
        if (fade_in_req && !fade_out_req) begin
          state_next = (level_reg == LVL_MAX) ? IDLE : FADE_IN;
          cnt_next   = '0;
        end else if (frame_tick) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            level_next = level_reg - LW'(1);
            if (level_reg == LW'(1)) state_next = DARK;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      DARK: begin
        if (fade_in_req && !fade_out_req) begin
          state_next = FADE_IN;
          cnt_next   = '0;
        end
      end
      FADE_IN: begin
        if (fade_out_req) begin
          state_next = (level_reg == '0) ? DARK : FADE_OUT;
          cnt_next   = '0;
        end else if (frame_tick) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            level_next = level_reg + LW'(1);
            if (level_reg == LVL_MAX - LW'(1)) state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        level_next = LVL_MAX;
      end
    endcase
  end

  assign level = level_reg;
  assign busy  = (state_reg == FADE_OUT) || (state_reg == FADE_IN);

endmodule

// File: rtl/palette_mapper.sv
// Colour-code to RGB mapper for the VGA path: writable palette, two-stage
// pipeline (lookup, then fade/blank) and the fade engine instance.
module palette_mapper
  import palette_pkg::*;
#(
  parameter int CODE_W      = CODE_W_DEF,
  parameter int COLOR_W     = COLOR_W_DEF,
  parameter int FADE_SHIFT  = FADE_SHIFT_DEF,
  parameter int FADE_PERIOD = FADE_PERIOD_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 pix_valid,
  input  logic [CODE_W-1:0]    colorcode,
  input  logic                 blank,
  input  logic                 pal_we,
  input  logic [CODE_W-1:0]    pal_waddr,
  input  logic [3*COLOR_W-1:0] pal_wdata,
  input  logic                 frame_tick,
  input  logic                 fade_out_req,
  input  logic                 fade_in_req,
  output logic [COLOR_W-1:0]   VGA_R,
  output logic [COLOR_W-1:0]   VGA_G,
  output logic [COLOR_W-1:0]   VGA_B,
  output logic                 pix_valid_o,
  output logic [FADE_SHIFT:0]  fade_level,
  output logic                 fade_busy
);

  localparam int PW    = 3 * COLOR_W;
  localparam int DEPTH = 2 ** CODE_W;
  localparam int PRODW = COLOR_W + FADE_SHIFT + 1;

  logic [PW-1:0]      pal_reg [DEPTH];
  logic [PW-1:0]      rgb1_reg;
  logic               blank1_reg;
  logic               v1_reg;
  logic [COLOR_W-1:0] ch_scaled [3];

  // Channel times level, divided by full scale; level <= full scale so the
  // truncation to COLOR_W never drops significant bits.
  function automatic logic [COLOR_W-1:0] scale_ch(input logic [COLOR_W-1:0] c,
                                                  input logic [FADE_SHIFT:0] lvl);
    logic [PRODW-1:0] prod;
    prod = PRODW'(c) * PRODW'(lvl);
    prod = prod >> FADE_SHIFT;
    return prod[COLOR_W-1:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_pal
      // Palette entry: reloads its default on reset, written by pal_we.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          pal_reg[gi] <= PW'(default_rgb(gi));
        end else if (pal_we && (pal_waddr == CODE_W'(gi))) begin
          pal_reg[gi] <= pal_wdata;
        end
      end
    end
    for (gi = 0; gi < 3; gi++) begin : g_ch
      assign ch_scaled[gi] = scale_ch(rgb1_reg[gi*COLOR_W +: COLOR_W], fade_level);
    end
  endgenerate

  // Stage 1: palette lookup; a same-cycle write is seen one pixel later.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rgb1_reg   <= '0;
      blank1_reg <= 1'b0;
      v1_reg     <= 1'b0;
    end else begin
      rgb1_reg   <= pal_reg[colorcode];
      blank1_reg <= blank;
      v1_reg     <= pix_valid;
    end
  end

  // Stage 2: apply blanking and fade level; data is not gated by pix_valid.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      pix_valid_o <= 1'b0;
    end else begin
      VGA_R       <= blank1_reg ? '0 : ch_scaled[2];
      VGA_G       <= blank1_reg ? '0 : ch_scaled[1];
      VGA_B       <= blank1_reg ? '0 : ch_scaled[0];
      pix_valid_o <= v1_reg;
    end
  end

  palette_mapper_fade_ctrl #(
    .FADE_SHIFT (FADE_SHIFT),
    .FADE_PERIOD(FADE_PERIOD)
  ) u_fade (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .fade_out_req(fade_out_req),
    .fade_in_req (fade_in_req),
    .level       (fade_level),
    .busy        (fade_busy)
  );

endmodule
